// File: rtl/arctan2_scheduler.sv
// Round-robin arbiter that time-shares one arctan2 divider/lookup unit among
// NUM_REQ requesters, drives its Start/Done handshake and returns tagged results.
module arctan2_scheduler #(
    parameter int unsigned TAMANYO = 32,
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TIMEOUT = 128,
    parameter int unsigned IDW     = $clog2(NUM_REQ)
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [NUM_REQ*TAMANYO-1:0] num_i,
    input  logic [NUM_REQ*TAMANYO-1:0] den_i,
    output logic [NUM_REQ-1:0]         ack_o,
    output logic                       start_o,
    output logic [TAMANYO-1:0]         num_o,
    output logic [TAMANYO-1:0]         den_o,
    input  logic                       done_i,
    input  logic [TAMANYO-1:0]         coc_i,
    input  logic [31:0]                angle_i,
    output logic                       res_valid_o,
    output logic [IDW-1:0]             res_id_o,
    output logic [TAMANYO-1:0]         res_coc_o,
    output logic [31:0]                res_angle_o,
    output logic                       res_err_o,
    output logic                       busy_o
);

    localparam int unsigned CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_RELEASE
    } state_t;

    state_t               state_q;
    logic [IDW-1:0]       last_q;
    logic [IDW-1:0]       cur_id_q;
    logic [CW-1:0]        cnt_q;
    logic [NUM_REQ-1:0]   ack_q;
    logic                 start_q;
    logic [TAMANYO-1:0]   num_q;
    logic [TAMANYO-1:0]   den_q;
    logic                 res_valid_q;
    logic [IDW-1:0]       res_id_q;
    logic [TAMANYO-1:0]   res_coc_q;
    logic [31:0]          res_angle_q;
    logic                 res_err_q;

    logic                 grant_vld_d;
    logic [IDW-1:0]       grant_id_d;
    logic [IDW-1:0]       scan_idx;

    // Scan upward from the requester after the last winner, wrapping around.
    always_comb begin
        grant_vld_d = 1'b0;
        grant_id_d  = '0;
        scan_idx    = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            scan_idx = IDW'((32'(last_q) + i) % NUM_REQ);
            if (!grant_vld_d && req_i[scan_idx]) begin
                grant_vld_d = 1'b1;
                grant_id_d  = scan_idx;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            last_q      <= IDW'(NUM_REQ - 1);
            cur_id_q    <= '0;
            cnt_q       <= '0;
            ack_q       <= '0;
            start_q     <= 1'b0;
            num_q       <= '0;
            den_q       <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_coc_q   <= '0;
            res_angle_q <= '0;
            res_err_q   <= 1'b0;
        end else begin
            ack_q       <= '0;
            res_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (grant_vld_d) begin
                        num_q              <= num_i[grant_id_d*TAMANYO +: TAMANYO];
                        den_q              <= den_i[grant_id_d*TAMANYO +: TAMANYO];
                        cur_id_q           <= grant_id_d;
                        last_q             <= grant_id_d;
                        ack_q[grant_id_d]  <= 1'b1;
                        cnt_q              <= '0;
                        start_q            <= 1'b1;
                        state_q            <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    cnt_q <= cnt_q + 1'b1;
                    // Done takes priority over a timeout landing on the same edge.
                    if (done_i) begin
                        res_valid_q <= 1'b1;
                        res_id_q    <= cur_id_q;
                        res_coc_q   <= coc_i;
                        res_angle_q <= angle_i;
                        res_err_q   <= 1'b0;
                        start_q     <= 1'b0;
                        state_q     <= S_RELEASE;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        res_valid_q <= 1'b1;
                        res_id_q    <= cur_id_q;
                        res_coc_q   <= '0;
                        res_angle_q <= '0;
                        res_err_q   <= 1'b1;
                        start_q     <= 1'b0;
                        state_q     <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    start_q <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ack_o       = ack_q;
    assign start_o     = start_q;
    assign num_o       = num_q;
    assign den_o       = den_q;
    assign res_valid_o = res_valid_q;
    assign res_id_o    = res_id_q;
    assign res_coc_o   = res_coc_q;
    assign res_angle_o = res_angle_q;
    assign res_err_o   = res_err_q;
    assign busy_o      = (state_q != S_IDLE);

endmodule
